// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback pipeline stage with vector-wide data memory.
// Stores retire silently, ALU ops retire next cycle, loads take one extra cycle through a registered read.
module mem_wb_stage #(
   parameter int REGI_BITS  = 4,
   parameter int REGI_SIZE  = 16,
   parameter int ELEM_SIZE  = 8,
   parameter int VECT_SIZE  = 8,
   parameter int MEMO_LINES = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [REGI_SIZE-1:0]           ialu_res_i,
   input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
   input  logic [ELEM_SIZE*VECT_SIZE-1:0] mem_data_i,
   input  logic [1:0]                     alu_flags_i,
   input  logic                           mem_read_i,
   input  logic                           mem_write_i,
   input  logic                           is_vec_i,
   input  logic                           wb_en_i,
   input  logic [REGI_BITS-1:0]           wb_addr_i,
   output logic                           wb_valid_o,
   output logic [REGI_BITS-1:0]           wb_addr_o,
   output logic                           wb_is_vec_o,
   output logic [REGI_SIZE-1:0]           wb_int_o,
   output logic [ELEM_SIZE*VECT_SIZE-1:0] wb_vec_o,
   output logic [1:0]                     flags_o
);

   localparam int VW = ELEM_SIZE * VECT_SIZE;
   localparam int AW = (MEMO_LINES > 1) ? $clog2(MEMO_LINES) : 1;

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [REGI_BITS-1:0]  wb_addr_q, wb_addr_d;
   logic                  wb_is_vec_q, wb_is_vec_d;
   logic [REGI_SIZE-1:0]  wb_int_q, wb_int_d;
   logic [VW-1:0]         wb_vec_q, wb_vec_d;
   logic [1:0]            flags_q, flags_d;

   // Sideband of an in-flight load, released together with the read data.
   logic                  pend_en_q, pend_en_d;
   logic [REGI_BITS-1:0]  pend_addr_q, pend_addr_d;
   logic                  pend_is_vec_q, pend_is_vec_d;
   logic [1:0]            pend_flags_q, pend_flags_d;

   logic [VW-1:0]         mem_q [MEMO_LINES];
   logic [VW-1:0]         rd_data_q, rd_data_d;

   logic                  accept;
   logic                  mem_we;
   logic                  mem_re;
   logic [AW-1:0]         addr;

   assign accept = valid_i & ready_q;
   assign addr   = ialu_res_i[AW-1:0];
   // A simultaneous read and write request is a store.
   assign mem_we = accept & mem_write_i;
   assign mem_re = accept & mem_read_i & ~mem_write_i;

   always_comb begin
      rd_data_d = rd_data_q;
      if (mem_re) begin
         rd_data_d = mem_q[addr];
      end
   end

   always_comb begin
      state_d       = state_q;
      wb_valid_d    = 1'b0;
      wb_addr_d     = wb_addr_q;
      wb_is_vec_d   = wb_is_vec_q;
      wb_int_d      = wb_int_q;
      wb_vec_d      = wb_vec_q;
      flags_d       = flags_q;
      pend_en_d     = pend_en_q;
      pend_addr_d   = pend_addr_q;
      pend_is_vec_d = pend_is_vec_q;
      pend_flags_d  = pend_flags_q;
      case (state_q)
         IDLE: begin
            if (accept && !mem_write_i) begin
               if (mem_read_i) begin
                  pend_en_d     = wb_en_i;
                  pend_addr_d   = wb_addr_i;
                  pend_is_vec_d = is_vec_i;
                  pend_flags_d  = alu_flags_i;
                  state_d       = LOAD_WAIT;
               end else begin
                  wb_valid_d  = wb_en_i;
                  wb_addr_d   = wb_addr_i;
                  wb_is_vec_d = is_vec_i;
                  wb_int_d    = ialu_res_i;
                  wb_vec_d    = valu_res_i;
                  flags_d     = alu_flags_i;
               end
            end
         end
         LOAD_WAIT: begin
            wb_valid_d  = pend_en_q;
            wb_addr_d   = pend_addr_q;
            wb_is_vec_d = pend_is_vec_q;
            wb_int_d    = rd_data_q[REGI_SIZE-1:0];
            wb_vec_d    = rd_data_q;
            flags_d     = pend_flags_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         ready_q       <= 1'b1;
         wb_valid_q    <= 1'b0;
         wb_addr_q     <= '0;
         wb_is_vec_q   <= 1'b0;
         wb_int_q      <= '0;
         wb_vec_q      <= '0;
         flags_q       <= '0;
         pend_en_q     <= 1'b0;
         pend_addr_q   <= '0;
         pend_is_vec_q <= 1'b0;
         pend_flags_q  <= '0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         wb_valid_q    <= wb_valid_d;
         wb_addr_q     <= wb_addr_d;
         wb_is_vec_q   <= wb_is_vec_d;
         wb_int_q      <= wb_int_d;
         wb_vec_q      <= wb_vec_d;
         flags_q       <= flags_d;
         pend_en_q     <= pend_en_d;
         pend_addr_q   <= pend_addr_d;
         pend_is_vec_q <= pend_is_vec_d;
         pend_flags_q  <= pend_flags_d;
      end
   end

   // Memory array and its read register are intentionally left out of reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[addr] <= mem_data_i;
      end
      rd_data_q <= rd_data_d;
   end

   assign ready_o     = ready_q;
   assign wb_valid_o  = wb_valid_q;
   assign wb_addr_o   = wb_addr_q;
   assign wb_is_vec_o = wb_is_vec_q;
   assign wb_int_o    = wb_int_q;
   assign wb_vec_o    = wb_vec_q;
   assign flags_o     = flags_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [15:0] ialu_res_i;
   logic [63:0] valu_res_i;
   logic [63:0] mem_data_i;
   logic [1:0]  alu_flags_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic        is_vec_i;
   logic        wb_en_i;
   logic [3:0]  wb_addr_i;
   logic        wb_valid_o;
   logic [3:0]  wb_addr_o;
   logic        wb_is_vec_o;
   logic [15:0] wb_int_o;
   logic [63:0] wb_vec_o;
   logic [1:0]  flags_o;

   int errors = 0;
   int checks = 0;

   mem_wb_stage dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .ialu_res_i  (ialu_res_i),
      .valu_res_i  (valu_res_i),
      .mem_data_i  (mem_data_i),
      .alu_flags_i (alu_flags_i),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .is_vec_i    (is_vec_i),
      .wb_en_i     (wb_en_i),
      .wb_addr_i   (wb_addr_i),
      .wb_valid_o  (wb_valid_o),
      .wb_addr_o   (wb_addr_o),
      .wb_is_vec_o (wb_is_vec_o),
      .wb_int_o    (wb_int_o),
      .wb_vec_o    (wb_vec_o),
      .flags_o     (flags_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [15:0] ialu,
                        input logic [63:0] data, input logic en, input logic [3:0] waddr,
                        input logic vec, input logic [1:0] fl);
      valid_i     = v;
      mem_read_i  = rd;
      mem_write_i = wr;
      ialu_res_i  = ialu;
      mem_data_i  = data;
      valu_res_i  = ~data;
      wb_en_i     = en;
      wb_addr_i   = waddr;
      is_vec_i    = vec;
      alu_flags_i = fl;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      #12;
      chk("rst_valid", {63'b0, wb_valid_o}, 64'd0);
      chk("rst_addr", {60'b0, wb_addr_o}, 64'd0);
      chk("rst_int", {48'b0, wb_int_o}, 64'd0);
      chk("rst_vec", wb_vec_o, 64'd0);
      chk("rst_flags", {62'b0, flags_o}, 64'd0);
      rst_i = 1'b0;
      step();
      chk("rst_ready", {63'b0, ready_o}, 64'd1);

      // ALU op retires one cycle later; outputs hold afterwards.
      drive(1, 0, 0, 16'h00A5, 64'h1111_2222_3333_4444, 1, 4'd3, 0, 2'b10);
      step();
      chk("alu_valid", {63'b0, wb_valid_o}, 64'd1);
      chk("alu_int", {48'b0, wb_int_o}, 64'h00A5);
      chk("alu_addr", {60'b0, wb_addr_o}, 64'd3);
      chk("alu_vec", wb_vec_o, ~64'h1111_2222_3333_4444);
      chk("alu_flags", {62'b0, flags_o}, 64'd2);
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      step();
      chk("alu_pulse", {63'b0, wb_valid_o}, 64'd0);
      chk("alu_hold", {48'b0, wb_int_o}, 64'h00A5);

      // Store then load next cycle; valid during LOAD_WAIT is ignored.
      drive(1, 0, 1, 16'd5, 64'h0123456789ABCDEF, 1, 4'd1, 0, 2'b00);
      step();
      chk("st_nowb", {63'b0, wb_valid_o}, 64'd0);
      chk("st_ready", {63'b0, ready_o}, 64'd1);
      drive(1, 1, 0, 16'd5, 64'h0, 1, 4'd9, 1, 2'b01);
      step();
      chk("ld_ready0", {63'b0, ready_o}, 64'd0);
      chk("ld_wait_nowb", {63'b0, wb_valid_o}, 64'd0);
      drive(1, 0, 0, 16'hBEEF, 64'hDEAD, 1, 4'd2, 0, 2'b11);
      step();
      chk("ld_valid", {63'b0, wb_valid_o}, 64'd1);
      chk("ld_vec", wb_vec_o, 64'h0123456789ABCDEF);
      chk("ld_int", {48'b0, wb_int_o}, 64'hCDEF);
      chk("ld_addr", {60'b0, wb_addr_o}, 64'd9);
      chk("ld_isvec", {63'b0, wb_is_vec_o}, 64'd1);
      chk("ld_flags", {62'b0, flags_o}, 64'd1);
      chk("ld_ready1", {63'b0, ready_o}, 64'd1);
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      step();
      chk("ld_ignored", {48'b0, wb_int_o}, 64'hCDEF);
      chk("ld_pulse", {63'b0, wb_valid_o}, 64'd0);

      // Address wrap: 0x45 aliases line 5.
      drive(1, 0, 1, 16'h0045, 64'hFEDCBA9876543210, 1, 4'd0, 0, 2'b00);
      step();
      drive(1, 1, 0, 16'd5, 64'h0, 1, 4'd4, 1, 2'b00);
      step();
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      step();
      chk("wrap_valid", {63'b0, wb_valid_o}, 64'd1);
      chk("wrap_vec", wb_vec_o, 64'hFEDCBA9876543210);

      // Read and write together behaves as a store.
      drive(1, 1, 1, 16'd7, 64'h1, 1, 4'd6, 0, 2'b00);
      step();
      chk("rw_nowb", {63'b0, wb_valid_o}, 64'd0);
      chk("rw_ready", {63'b0, ready_o}, 64'd1);
      drive(1, 1, 0, 16'd7, 64'h0, 1, 4'd6, 0, 2'b00);
      step();
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      step();
      chk("rw_ld_valid", {63'b0, wb_valid_o}, 64'd1);
      chk("rw_ld_vec", wb_vec_o, 64'h1);

      // Reset in LOAD_WAIT aborts the load.
      drive(1, 1, 0, 16'd5, 64'h0, 1, 4'd8, 1, 2'b11);
      step();
      chk("ab_ready0", {63'b0, ready_o}, 64'd0);
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      #1 rst_i = 1'b1;
      #1;
      chk("ab_valid", {63'b0, wb_valid_o}, 64'd0);
      chk("ab_vec", wb_vec_o, 64'd0);
      chk("ab_int", {48'b0, wb_int_o}, 64'd0);
      chk("ab_addr", {60'b0, wb_addr_o}, 64'd0);
      step();
      rst_i = 1'b0;
      step();
      chk("ab_nowb", {63'b0, wb_valid_o}, 64'd0);
      chk("ab_ready1", {63'b0, ready_o}, 64'd1);

      // Back-to-back ALU ops with alternating writeback enable.
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 16'h0010 + 16'(i), 64'h0, ((i % 2) == 0), 4'(i), 0, 2'b00);
         step();
         chk("b2b_valid", {63'b0, wb_valid_o}, ((i % 2) == 0) ? 64'd1 : 64'd0);
         chk("b2b_int", {48'b0, wb_int_o}, 64'h10 + 64'(i));
         chk("b2b_ready", {63'b0, ready_o}, 64'd1);
      end
      drive(0, 0, 0, 16'h0, 64'h0, 0, 4'h0, 0, 2'b00);
      step();
      chk("b2b_end", {63'b0, wb_valid_o}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter REGI_BITS, default 4, register-index width.
REQ-002 SHALL have parameter REGI_SIZE, default 16, scalar width.
REQ-003 SHALL have parameter ELEM_SIZE, default 8, vector element width.
REQ-004 SHALL have parameter VECT_SIZE, default 8, elements per vector.
REQ-005 SHALL have parameter MEMO_LINES, default 64, data-memory depth in vector words.
REQ-006 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port valid_i  input  1  execute result presented.
REQ-009 SHALL have port ready_o  output  1  stage accepts this cycle.
REQ-010 SHALL have port ialu_res_i  input  REGI_SIZE  scalar result; bits [log2(MEMO_LINES)-1:0] give the memory address.
REQ-011 SHALL have port valu_res_i  input  ELEM_SIZE*VECT_SIZE  vector result.
REQ-012 SHALL have port mem_data_i  input  ELEM_SIZE*VECT_SIZE  store data.
REQ-013 SHALL have port alu_flags_i  input  2  ALU flags.
REQ-014 SHALL have ports mem_read_i, mem_write_i, is_vec_i, wb_en_i  input  1 each  load, store, vector destination, writeback request.
REQ-015 SHALL have port wb_addr_i  input  REGI_BITS  destination register.
REQ-016 SHALL have ports wb_valid_o (1), wb_addr_o (REGI_BITS), wb_is_vec_o (1), wb_int_o (REGI_SIZE), wb_vec_o (ELEM_SIZE*VECT_SIZE), flags_o (2)  output  writeback bundle.

Function
REQ-017 SHALL contain MEMO_LINES x (ELEM_SIZE*VECT_SIZE) data memory, synchronous write, registered read.
REQ-018 SHALL implement FSM states IDLE and LOAD_WAIT; ready_o=1 only in IDLE.
REQ-019 Accept = valid_i & ready_o; no state change without accept in IDLE.
REQ-020 Accepted store (mem_write_i=1): memory[addr] <= mem_data_i at that edge; no writeback; wb_valid_o=0 next cycle; stays IDLE.
REQ-021 mem_read_i and mem_write_i both 1 SHALL be treated as store; read ignored.
REQ-022 Accepted load: memory read registered at accept edge, go LOAD_WAIT; next edge drive wb_vec_o=read data, wb_int_o=read data[REGI_SIZE-1:0], wb_valid_o=wb_en_i, return IDLE; latency 2 cycles accept-to-wb_valid_o.
REQ-023 Accepted ALU op (no load/store): next edge wb_int_o=ialu_res_i, wb_vec_o=valu_res_i, wb_valid_o=wb_en_i; latency 1 cycle.
REQ-024 wb_addr_o, wb_is_vec_o, flags_o SHALL be captured at accept and held with the corresponding result.
REQ-025 wb_valid_o SHALL be a single-cycle pulse per retired op; 0 on cycles without retirement; other wb outputs hold last value.
REQ-026 Load accepted on the cycle after a store to same address SHALL return the stored data.
REQ-027 Addresses wrap modulo MEMO_LINES (upper ialu_res_i bits ignored).
REQ-028 valid_i during LOAD_WAIT SHALL be ignored (upstream holds it until ready_o).

Reset
REQ-029 rst_i asserted: immediately state=IDLE, ready_o=1 after deassert, wb_valid_o=0, wb_addr_o=0, wb_is_vec_o=0, wb_int_o=0, wb_vec_o=0, flags_o=0.
REQ-030 Reset during LOAD_WAIT SHALL abort the load; no wb_valid_o pulse.
REQ-031 Memory contents SHALL NOT be reset.

Verification
REQ-032 ALU op ialu_res_i=16'h00A5, wb_en_i=1, wb_addr_i=3 -> next cycle wb_valid_o=1, wb_int_o=16'h00A5, wb_addr_o=3.
REQ-033 Store addr 5 data 64'h0123456789ABCDEF, then load addr 5 next cycle -> ready_o=0 one cycle, then wb_vec_o=64'h0123456789ABCDEF, wb_valid_o=1.
REQ-034 Store to ialu_res_i=16'h0045 then load addr 5 -> same data (wrap).
REQ-035 read and write both set, addr 7 data 64'h1 -> no wb_valid_o; later load addr 7 returns 64'h1.
REQ-036 rst_i pulse during LOAD_WAIT -> all outputs 0, no wb_valid_o, ready_o=1 afterwards.
REQ-037 Back-to-back ALU ops every cycle, wb_en_i alternating 1/0 -> wb_valid_o alternates, one result per cycle, ready_o held 1.
